// File: rtl/cache_wb_ctrl_if.sv
// Purpose: signal bundle between the LSU/tag array/memory port and cache_wb_ctrl.
// Ports:   slave modport is the controller view, master modport is the environment view.
// Latency: none, pure wiring. Backpressure: memory beats advance only on mem_ready.
interface cache_wb_ctrl_if #(
  parameter int WORDS_PER_LINE = 4
);
  // Request side
  logic                              req_valid;
  logic                              req_we;
  logic                              hit;
  logic                              dirty;
  // Memory beat handshake
  logic                              mem_ready;
  // Controller outputs
  logic                              stall;
  logic                              reg_write_enable;
  logic                              cache_we;
  logic                              cache_in_select;
  logic                              tag_we;
  logic                              mem_we;
  logic                              mem_re;
  logic                              mem_in_select;
  logic [$clog2(WORDS_PER_LINE)-1:0] beat_idx;

  modport slave (
    input  req_valid, req_we, hit, dirty, mem_ready,
    output stall, reg_write_enable, cache_we, cache_in_select, tag_we,
           mem_we, mem_re, mem_in_select, beat_idx
  );

  modport master (
    output req_valid, req_we, hit, dirty, mem_ready,
    input  stall, reg_write_enable, cache_we, cache_in_select, tag_we,
           mem_we, mem_re, mem_in_select, beat_idx
  );
endinterface

// File: rtl/cache_wb_ctrl.sv
// Purpose: write-back cache controller; hit service, dirty-line write-back, multi-beat refill.
// Latency: hits complete in the request cycle; misses stall until the line is refilled and replayed.
// Backpressure: each memory beat waits for a mem_ready pulse; stall holds the pipeline meanwhile.
// Ports: clk, rst_b (async active-low), bus (cache_wb_ctrl_if.slave).
//        Optional macro CACHE_WB_CTRL_STATS_EN adds hit_count/miss_count/wb_count outputs.
module cache_wb_ctrl #(
  parameter int WORDS_PER_LINE = 4,
  parameter int BEAT_W         = $clog2(WORDS_PER_LINE)
) (
  input  logic                clk,
  input  logic                rst_b,
  cache_wb_ctrl_if.slave      bus
`ifdef CACHE_WB_CTRL_STATS_EN
  ,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count,
  output logic [31:0]         wb_count
`endif
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] FILL      = 2'd2;
  localparam logic [1:0] RESOLVE   = 2'd3;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

  logic [1:0]        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  logic stall, rwe, c_we, c_sel, t_we, m_we, m_re, m_sel;
  logic miss_start, wb_start;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    stall      = 1'b0;
    rwe        = 1'b0;
    c_we       = 1'b0;
    c_sel      = 1'b0;
    t_we       = 1'b0;
    m_we       = 1'b0;
    m_re       = 1'b0;
    m_sel      = 1'b0;
    miss_start = 1'b0;
    wb_start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.hit) begin
            rwe   = !bus.req_we;
            c_we  = bus.req_we;
            c_sel = bus.req_we;
          end else begin
            stall      = 1'b1;
            beat_d     = '0;
            miss_start = 1'b1;
            wb_start   = bus.dirty;
            state_d    = bus.dirty ? WRITEBACK : FILL;
          end
        end
      end
      WRITEBACK: begin
        stall = 1'b1;
        m_we  = 1'b1;
        m_sel = 1'b1;
        if (bus.mem_ready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = FILL;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      FILL: begin
        stall = 1'b1;
        m_re  = 1'b1;
        if (bus.mem_ready) begin
          // Fill data is written in the same cycle the beat completes.
          c_we   = 1'b1;
          beat_d = beat_q + 1'b1;  // wraps to 0 on the last beat
          if (beat_q == LAST_BEAT) state_d = RESOLVE;
        end
      end
      default: begin  // RESOLVE
        stall   = 1'b1;
        t_we    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Outputs are forced low while reset is held so an in-flight request
  // cannot raise stall or enables before reset releases.
  assign bus.stall            = rst_b & stall;
  assign bus.reg_write_enable = rst_b & rwe;
  assign bus.cache_we         = rst_b & c_we;
  assign bus.cache_in_select  = rst_b & c_sel;
  assign bus.tag_we           = rst_b & t_we;
  assign bus.mem_we           = rst_b & m_we;
  assign bus.mem_re           = rst_b & m_re;
  assign bus.mem_in_select    = rst_b & m_sel;
  assign bus.beat_idx         = beat_q;

`ifdef CACHE_WB_CTRL_STATS_EN
  logic        replay_q, replay_d;
  logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;
  logic        hit_evt;

  // The replay after a refill is the same request, so it is not a new hit.
  assign hit_evt  = (state_q == IDLE) && bus.req_valid && bus.hit && !replay_q;
  assign replay_d = (state_q == RESOLVE) ? 1'b1 :
                    (state_q == IDLE)    ? 1'b0 : replay_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      replay_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      replay_q <= replay_d;
      if (hit_evt)    hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_start) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (wb_start)   wb_cnt_q   <= wb_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign wb_count   = wb_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = miss_start ^ wb_start;
`endif

endmodule

// File: tb/tb_cache_wb_ctrl.sv
// Directed bench for cache_wb_ctrl: a 4-word-line and an 8-word-line instance
// share one clock and reset. Inputs change 1ns after the rising edge and
// outputs are sampled on the falling edge.
module tb_cache_wb_ctrl;
  logic clk = 1'b0;
  logic rst_b = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cache_wb_ctrl_if #(.WORDS_PER_LINE(4)) b4 ();
  cache_wb_ctrl_if #(.WORDS_PER_LINE(8)) b8 ();

`ifdef CACHE_WB_CTRL_STATS_EN
  logic [31:0] h4, m4, w4, h8, m8, w8;
`endif

  cache_wb_ctrl #(.WORDS_PER_LINE(4)) u4 (
    .clk(clk), .rst_b(rst_b), .bus(b4)
`ifdef CACHE_WB_CTRL_STATS_EN
    , .hit_count(h4), .miss_count(m4), .wb_count(w4)
`endif
  );

  cache_wb_ctrl #(.WORDS_PER_LINE(8)) u8 (
    .clk(clk), .rst_b(rst_b), .bus(b8)
`ifdef CACHE_WB_CTRL_STATS_EN
    , .hit_count(h8), .miss_count(m8), .wb_count(w8)
`endif
  );

  task automatic idle_inputs();
    b4.req_valid = 0; b4.req_we = 0; b4.hit = 0; b4.dirty = 0; b4.mem_ready = 0;
    b8.req_valid = 0; b8.req_we = 0; b8.hit = 0; b8.dirty = 0; b8.mem_ready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (b4.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", b4.stall); end
    n_tests++; if (b4.beat_idx !== 2'd0) begin n_fail++; $display("FAIL reset_beat: got %0d want 0", b4.beat_idx); end
    n_tests++; if ({b4.mem_we, b4.mem_re, b4.cache_we, b4.tag_we, b4.reg_write_enable} !== 5'b0) begin
      n_fail++; $display("FAIL reset_enables: got %b want 00000", {b4.mem_we, b4.mem_re, b4.cache_we, b4.tag_we, b4.reg_write_enable}); end
    n_tests++; if (b8.beat_idx !== 3'd0) begin n_fail++; $display("FAIL reset_beat8: got %0d want 0", b8.beat_idx); end
    // A missing request presented while reset is held must not stall.
    b4.req_valid = 1; b4.hit = 0;
    #1;
    n_tests++; if (b4.stall !== 1'b0) begin n_fail++; $display("FAIL reset_gate_stall: got %b want 0", b4.stall); end
`ifdef CACHE_WB_CTRL_STATS_EN
    n_tests++; if (h8 !== 32'd0 || m8 !== 32'd0 || w8 !== 32'd0) begin
      n_fail++; $display("FAIL reset_stats: got %0d/%0d/%0d want 0/0/0", h8, m8, w8); end
`endif
    idle_inputs();
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic test_lw_hit();
    @(posedge clk); #1;
    b4.req_valid = 1; b4.hit = 1; b4.req_we = 0;
    @(negedge clk);
    n_tests++; if (b4.reg_write_enable !== 1'b1) begin n_fail++; $display("FAIL lw_hit_rwe: got %b want 1", b4.reg_write_enable); end
    n_tests++; if (b4.stall !== 1'b0) begin n_fail++; $display("FAIL lw_hit_stall: got %b want 0", b4.stall); end
    n_tests++; if ({b4.mem_re, b4.mem_we, b4.cache_we} !== 3'b000) begin
      n_fail++; $display("FAIL lw_hit_mem: got %b want 000", {b4.mem_re, b4.mem_we, b4.cache_we}); end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_sw_hit();
    @(posedge clk); #1;
    b4.req_valid = 1; b4.hit = 1; b4.req_we = 1;
    @(negedge clk);
    n_tests++; if ({b4.cache_we, b4.cache_in_select} !== 2'b11) begin
      n_fail++; $display("FAIL sw_hit_write: got %b want 11", {b4.cache_we, b4.cache_in_select}); end
    n_tests++; if (b4.stall !== 1'b0) begin n_fail++; $display("FAIL sw_hit_stall: got %b want 0", b4.stall); end
    n_tests++; if (b4.reg_write_enable !== 1'b0) begin n_fail++; $display("FAIL sw_hit_rwe: got %b want 0", b4.reg_write_enable); end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_clean_miss();
    int  stalls = 0, fills = 0, tags = 0, reads = 0, writes = 0;
    bit  saw_tag = 0, done = 0;
    logic [1:0] exp_beat;
    @(posedge clk); #1;
    b4.req_valid = 1; b4.req_we = 0; b4.hit = 0; b4.dirty = 0; b4.mem_ready = 1;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk);
      if (b4.stall) begin
        stalls++;
        if (b4.mem_re) reads++;
        if (b4.mem_we) writes++;
        if (b4.cache_we) begin
          exp_beat = fills[1:0];
          n_tests++; if (b4.beat_idx !== exp_beat) begin n_fail++; $display("FAIL clean_fill_beat: got %0d want %0d", b4.beat_idx, exp_beat); end
          n_tests++; if (b4.cache_in_select !== 1'b0) begin n_fail++; $display("FAIL clean_fill_sel: got %b want 0", b4.cache_in_select); end
          fills++;
        end
        if (b4.tag_we) begin tags++; saw_tag = 1; end
      end else begin
        n_tests++; if (b4.reg_write_enable !== 1'b1) begin n_fail++; $display("FAIL clean_replay_rwe: got %b want 1", b4.reg_write_enable); end
        done = 1;
      end
      @(posedge clk); #1;
      if (saw_tag) b4.hit = 1;  // tag array now holds the line
    end
    idle_inputs();
    n_tests++; if (!done) begin n_fail++; $display("FAIL clean_timeout: got no replay want replay within 30 cycles"); end
    n_tests++; if (stalls != 6) begin n_fail++; $display("FAIL clean_stall_cycles: got %0d want 6", stalls); end
    n_tests++; if (fills != 4) begin n_fail++; $display("FAIL clean_fill_count: got %0d want 4", fills); end
    n_tests++; if (reads != 4) begin n_fail++; $display("FAIL clean_mem_re_count: got %0d want 4", reads); end
    n_tests++; if (writes != 0) begin n_fail++; $display("FAIL clean_mem_we_count: got %0d want 0", writes); end
    n_tests++; if (tags != 1) begin n_fail++; $display("FAIL clean_tag_count: got %0d want 1", tags); end
  endtask

  task automatic test_drop_valid();
    int stalls = 0, wbs = 0, fills = 0, tags = 0;
    bit done = 0;
    @(posedge clk); #1;
    b4.req_valid = 1; b4.req_we = 1; b4.hit = 0; b4.dirty = 1; b4.mem_ready = 1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (b4.stall) begin
        stalls++;
        if (b4.mem_we && b4.mem_ready) wbs++;
        if (b4.mem_re && b4.cache_we) fills++;
        if (b4.tag_we) tags++;
      end else begin
        n_tests++; if ({b4.reg_write_enable, b4.cache_we} !== 2'b00) begin
          n_fail++; $display("FAIL drop_no_replay: got %b want 00", {b4.reg_write_enable, b4.cache_we}); end
        done = 1;
      end
      @(posedge clk); #1;
      if (wbs > 0) b4.req_valid = 0;
    end
    idle_inputs();
    n_tests++; if (!done) begin n_fail++; $display("FAIL drop_timeout: got no return to idle want return within 40 cycles"); end
    n_tests++; if (stalls != 10) begin n_fail++; $display("FAIL drop_stall_cycles: got %0d want 10", stalls); end
    n_tests++; if (wbs != 4) begin n_fail++; $display("FAIL drop_wb_count: got %0d want 4", wbs); end
    n_tests++; if (fills != 4) begin n_fail++; $display("FAIL drop_fill_count: got %0d want 4", fills); end
    n_tests++; if (tags != 1) begin n_fail++; $display("FAIL drop_tag_count: got %0d want 1", tags); end
  endtask

  task automatic test_reset_mid_fill();
    @(posedge clk); #1;
    b4.req_valid = 1; b4.req_we = 0; b4.hit = 0; b4.dirty = 0; b4.mem_ready = 1;
    repeat (4) @(negedge clk);  // IDLE miss, FILL beat 0, 1, 2
    n_tests++; if ({b4.mem_re, b4.beat_idx} !== 3'b110) begin
      n_fail++; $display("FAIL midfill_pre: got re=%b beat=%0d want re=1 beat=2", b4.mem_re, b4.beat_idx); end
    b4.req_valid = 0; b4.mem_ready = 0;
    rst_b = 1'b0;
    #1;
    n_tests++; if (b4.beat_idx !== 2'd0) begin n_fail++; $display("FAIL midfill_beat: got %0d want 0", b4.beat_idx); end
    n_tests++; if ({b4.stall, b4.mem_re, b4.mem_we, b4.cache_we, b4.tag_we, b4.reg_write_enable} !== 6'b0) begin
      n_fail++; $display("FAIL midfill_outputs: got %b want 000000",
        {b4.stall, b4.mem_re, b4.mem_we, b4.cache_we, b4.tag_we, b4.reg_write_enable}); end
    @(negedge clk);
    rst_b = 1'b1;
    b4.mem_ready = 1;  // must be ignored in IDLE
    @(negedge clk);
    n_tests++; if ({b4.stall, b4.mem_re, b4.beat_idx} !== 4'b0000) begin
      n_fail++; $display("FAIL midfill_after_release: got stall=%b re=%b beat=%0d want 0 0 0", b4.stall, b4.mem_re, b4.beat_idx); end
    idle_inputs();
  endtask

  task automatic test_dirty_sw_miss();
    int wbs = 0, fills = 0, tags = 0;
    bit saw_tag = 0, done = 0;
    logic [2:0] exp_beat;
    @(posedge clk); #1;
    b8.req_valid = 1; b8.req_we = 1; b8.hit = 0; b8.dirty = 1; b8.mem_ready = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (b8.stall) begin
        if (b8.mem_we) begin
          exp_beat = wbs[2:0];
          n_tests++; if (b8.mem_in_select !== 1'b1) begin n_fail++; $display("FAIL dirty_wb_sel: got %b want 1", b8.mem_in_select); end
          n_tests++; if (b8.beat_idx !== exp_beat) begin n_fail++; $display("FAIL dirty_wb_beat: got %0d want %0d", b8.beat_idx, exp_beat); end
          if (b8.mem_ready) wbs++;
        end
        if (b8.mem_re) begin
          exp_beat = fills[2:0];
          n_tests++; if (wbs != 8) begin n_fail++; $display("FAIL dirty_order: got %0d wb beats before fill want 8", wbs); end
          n_tests++; if (b8.mem_in_select !== 1'b0) begin n_fail++; $display("FAIL dirty_fill_sel: got %b want 0", b8.mem_in_select); end
          n_tests++; if (b8.beat_idx !== exp_beat) begin n_fail++; $display("FAIL dirty_fill_beat: got %0d want %0d", b8.beat_idx, exp_beat); end
          n_tests++; if (b8.cache_we !== b8.mem_ready) begin n_fail++; $display("FAIL dirty_fill_we: got %b want %b", b8.cache_we, b8.mem_ready); end
          if (b8.mem_ready) fills++;
        end
        if (b8.tag_we) begin tags++; saw_tag = 1; end
      end else begin
        n_tests++; if ({b8.cache_we, b8.cache_in_select, b8.reg_write_enable} !== 3'b110) begin
          n_fail++; $display("FAIL dirty_replay_store: got %b want 110", {b8.cache_we, b8.cache_in_select, b8.reg_write_enable}); end
        done = 1;
      end
      @(posedge clk); #1;
      b8.mem_ready = (c % 3 == 1);  // one ready pulse every third cycle
      if (saw_tag) b8.hit = 1;
    end
    idle_inputs();
    n_tests++; if (!done) begin n_fail++; $display("FAIL dirty_timeout: got no replay want replay within 200 cycles"); end
    n_tests++; if (wbs != 8) begin n_fail++; $display("FAIL dirty_wb_count: got %0d want 8", wbs); end
    n_tests++; if (fills != 8) begin n_fail++; $display("FAIL dirty_fill_count: got %0d want 8", fills); end
    n_tests++; if (tags != 1) begin n_fail++; $display("FAIL dirty_tag_count: got %0d want 1", tags); end
    @(negedge clk);
`ifdef CACHE_WB_CTRL_STATS_EN
    n_tests++; if (m8 !== 32'd1) begin n_fail++; $display("FAIL stats_miss: got %0d want 1", m8); end
    n_tests++; if (w8 !== 32'd1) begin n_fail++; $display("FAIL stats_wb: got %0d want 1", w8); end
    n_tests++; if (h8 !== 32'd0) begin n_fail++; $display("FAIL stats_hit: got %0d want 0", h8); end
`endif
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_lw_hit();
    test_sw_hit();
    test_clean_miss();
    test_drop_valid();
    test_reset_mid_fill();
    test_dirty_sw_miss();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_wb_ctrl.md
# cache_wb_ctrl

Parametrised write-back cache controller for the single-cycle MIPS datapath. It sequences hit service, dirty-line write-back and multi-beat line refill against a handshaked main memory, and stalls the pipeline while a miss is outstanding. It sits between the decode/LSU request signals and the cache data/tag arrays and memory port. It generalises the earlier single-word, fixed-count controller to configurable line size and a ready-driven memory.

## Interface
Parameters:
- WORDS_PER_LINE, 4: words per cache line, which is also the number of memory beats per refill or write-back; power of two, ≥2.
- BEAT_W, $clog2(WORDS_PER_LINE): width of the beat index; derived, do not override.

Ports:
- clk  in  1  rising-edge clock
- rst_b  in  1  asynchronous, active-low reset
- req_valid  in  1  a load or store is presented this cycle
- req_we  in  1  1 = SW, 0 = LW; sampled only with req_valid
- hit  in  1  tag match and valid for the request address (combinational from the tag array)
- dirty  in  1  indexed victim line is dirty
- mem_ready  in  1  memory completed the current beat (one-cycle pulse per beat)
- stall  out  1  holds PC and pipeline
- reg_write_enable  out  1  load data to register file
- cache_we  out  1  data-array word write
- cache_in_select  out  1  1 = CPU store data, 0 = memory fill data
- tag_we  out  1  write tag, set valid, clear dirty
- mem_we  out  1  memory write request (write-back beat)
- mem_re  out  1  memory read request (fill beat)
- mem_in_select  out  1  memory address source: 1 = victim tag address, 0 = request address
- beat_idx  out  BEAT_W  word offset of the current beat

## Operation
- States: IDLE, WRITEBACK, FILL, RESOLVE. Beat counter `beat` (BEAT_W bits) drives beat_idx.
- Outputs are combinational from state and inputs. All outputs not listed for a state are 0.
- IDLE:
  - req_valid & hit & !req_we: reg_write_enable=1.
  - req_valid & hit & req_we: cache_we=1, cache_in_select=1.
  - req_valid & !hit: stall=1, beat←0. Next state is WRITEBACK if dirty, else FILL.
- WRITEBACK: stall=1, mem_we=1, mem_in_select=1.
  - On mem_ready: beat←beat+1.
  - On mem_ready with beat==WORDS_PER_LINE-1: beat←0, go to FILL.
- FILL: stall=1, mem_re=1, mem_in_select=0.
  - On mem_ready: cache_we=1, cache_in_select=0 (same cycle), beat←beat+1.
  - On mem_ready with the last beat: go to RESOLVE.
- RESOLVE: stall=1, tag_we=1; go to IDLE. The request is then replayed in IDLE and completes as a hit.
- A miss always completes the full line. Deasserting req_valid mid-miss does not abort.
- hit, dirty and req_we are ignored outside IDLE. mem_ready is ignored in IDLE and RESOLVE.
- A beat counter wrap past WORDS_PER_LINE-1 is impossible by construction.

## Timing
- Reset (asynchronous, rst_b=0): state←IDLE, beat←0. All outputs 0, statistics counters 0. Reset asserted mid-miss abandons the transfer immediately.
- Hit latency: 0 cycles, with no stall.
- Clean-miss penalty: 1 + sum of fill-beat waits + 1 (RESOLVE) cycles of stall before the replay cycle.
- Dirty-miss penalty: adds the write-back beats.
- Minimum clean miss with mem_ready held high: IDLE(stall) → WORDS_PER_LINE FILL cycles → RESOLVE → IDLE hit. That is WORDS_PER_LINE+2 stalled cycles.
- mem_ready held high continuously advances one beat per cycle.

## Configuration
- CACHE_WB_CTRL_STATS_EN:
  - Defined: adds 32-bit wrapping outputs hit_count, miss_count and wb_count, plus an internal `replay` flag set in RESOLVE and cleared in the next IDLE cycle.
  - hit_count increments on an IDLE req_valid&hit cycle with replay=0.
  - miss_count increments on each IDLE→WRITEBACK/FILL transition.
  - wb_count increments on each IDLE→WRITEBACK transition.
  - Undefined: the ports and logic are absent; behaviour is otherwise identical.

## Test plan
- Reset mid-FILL (beat=2, WORDS_PER_LINE=4) → next cycle state IDLE, beat_idx=0, stall=0, all enables 0.
- LW hit (req_valid=1, hit=1, req_we=0) → reg_write_enable=1 the same cycle, stall=0, no mem_re/mem_we.
- SW hit → cache_we=1, cache_in_select=1, no stall.
- Clean LW miss, mem_ready always 1, WORDS_PER_LINE=4:
  - stall high for 6 cycles; cache_we pulses 4 times with beat_idx 0,1,2,3.
  - tag_we high 1 cycle, then reg_write_enable=1 on replay.
- Dirty SW miss, mem_ready every 3rd cycle, WORDS_PER_LINE=8:
  - 8 mem_we beats with mem_in_select=1, then 8 fill beats.
  - beat_idx holds between ready pulses; the replay performs the store.
  - With stats enabled: miss_count=1, wb_count=1, hit_count=0.
- req_valid dropped during WRITEBACK → full write-back and fill still complete, and tag_we asserts once.
